// File: rtl/int_exec_unit.sv
// int_exec_unit: RV integer execute unit for OP/OP-IMM, with an iterative shifter and a one-slot output register.
// Define INT_EXEC_BRANCH_EN to enable branch-compare mode on in_br (otherwise in_br is ignored and out_taken is 0).
//
// state | meaning
// IDLE  | accepts a new op whenever the output slot is free or draining
// SHIFT | iterative shift running; remaining counts down to the terminal step
module int_exec_unit #(
  parameter int XLEN       = 32,
  parameter int SHIFT_STEP = 1
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [2:0]      in_funct3,
  input  logic            in_alt,
  input  logic            in_br,
  input  logic [XLEN-1:0] in_a,
  input  logic [XLEN-1:0] in_b,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [XLEN-1:0] out_result,
  output logic            out_taken,
  output logic            busy
);

  localparam int SW = $clog2(XLEN);
  localparam logic [SW:0] STEP_L = (SW+1)'(SHIFT_STEP);

  typedef enum logic {IDLE, SHIFT} state_t;

  state_t            state_q, state_d;
  logic [XLEN-1:0]   work_q;
  logic [SW:0]       rem_q;
  logic              left_q, arith_q;
  logic              valid_q, taken_q;
  logic [XLEN-1:0]   result_q;

  logic              accept, is_br, is_shift, last_step;
  logic              start_shift, load_out;
  logic [SW-1:0]     shamt;
  logic [SW:0]       step_amt;
  logic [XLEN-1:0]   shifted, alu_res, res_d;
  logic              alu_taken, taken_d;
  logic              br_unused;

  assign br_unused = in_br;
  assign shamt     = in_b[SW-1:0];
  assign in_ready  = rst_n && (state_q == IDLE) && (!valid_q || out_ready);
  assign accept    = in_valid && in_ready;
  assign busy      = (state_q == SHIFT);

  // Single-cycle ALU; the shift slots pass in_a through, which is the shamt=0 result.
  always_comb begin
    alu_res   = in_a;
    alu_taken = 1'b0;
    is_br     = 1'b0;
    case (in_funct3)
      3'b000:  alu_res = in_alt ? (in_a - in_b) : (in_a + in_b);
      3'b010:  alu_res = {{(XLEN-1){1'b0}}, ($signed(in_a) < $signed(in_b))};
      3'b011:  alu_res = {{(XLEN-1){1'b0}}, (in_a < in_b)};
      3'b100:  alu_res = in_a ^ in_b;
      3'b110:  alu_res = in_a | in_b;
      3'b111:  alu_res = in_a & in_b;
      default: alu_res = in_a;
    endcase
`ifdef INT_EXEC_BRANCH_EN
    if (in_br) begin
      is_br   = 1'b1;
      alu_res = '0;
      case (in_funct3)
        3'b000:  alu_taken = (in_a == in_b);
        3'b001:  alu_taken = (in_a != in_b);
        3'b100:  alu_taken = ($signed(in_a) <  $signed(in_b));
        3'b101:  alu_taken = ($signed(in_a) >= $signed(in_b));
        3'b110:  alu_taken = (in_a <  in_b);
        3'b111:  alu_taken = (in_a >= in_b);
        default: alu_taken = 1'b0;
      endcase
    end
`endif
    is_shift = !is_br && (in_funct3[1:0] == 2'b01);
  end

  always_comb begin
    last_step = (rem_q <= STEP_L);
    step_amt  = last_step ? rem_q : STEP_L;
    if (left_q)       shifted = work_q << step_amt;
    else if (arith_q) shifted = $signed(work_q) >>> step_amt;
    else              shifted = work_q >> step_amt;
  end

  always_comb begin
    state_d     = state_q;
    start_shift = 1'b0;
    load_out    = 1'b0;
    res_d       = alu_res;
    taken_d     = alu_taken;
    case (state_q)
      IDLE: begin
        if (accept) begin
          if (is_shift && (shamt != '0)) begin
            start_shift = 1'b1;
            state_d     = SHIFT;
          end else begin
            load_out = 1'b1;
          end
        end
      end
      SHIFT: begin
        res_d   = shifted;
        taken_d = 1'b0;
        if (last_step) begin
          load_out = 1'b1;
          state_d  = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= IDLE;
    else        state_q <= state_d;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      work_q   <= '0;
      rem_q    <= '0;
      left_q   <= 1'b0;
      arith_q  <= 1'b0;
      valid_q  <= 1'b0;
      result_q <= '0;
      taken_q  <= 1'b0;
    end else begin
      if (start_shift) begin
        work_q  <= in_a;
        rem_q   <= {1'b0, shamt};
        left_q  <= (in_funct3 == 3'b001);
        arith_q <= in_alt;
      end else if (state_q == SHIFT && !last_step) begin
        work_q <= shifted;
        rem_q  <= rem_q - STEP_L;
      end
      if (load_out) begin
        valid_q  <= 1'b1;
        result_q <= res_d;
        taken_q  <= taken_d;
      end else if (valid_q && out_ready) begin
        valid_q <= 1'b0;
      end
    end
  end

  assign out_valid  = valid_q;
  assign out_result = result_q;
  assign out_taken  = taken_q;

endmodule

// File: tb/tb_int_exec_unit.sv
// Self-checking bench for int_exec_unit: directed scenarios plus randomized ops against a whole-shift reference model.
// A second instance with SHIFT_STEP=4 covers multi-bit shift steps.
module tb_int_exec_unit;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        in_valid, in_valid_4;
  logic [2:0]  in_funct3;
  logic        in_alt, in_br;
  logic [31:0] in_a, in_b;
  logic        out_ready;
  logic        in_ready, out_valid, out_taken, busy;
  logic [31:0] out_result;
  logic        in_ready_4, out_valid_4, out_taken_4, busy_4;
  logic [31:0] out_result_4;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  int_exec_unit #(.XLEN(32), .SHIFT_STEP(1)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .in_funct3(in_funct3), .in_alt(in_alt), .in_br(in_br), .in_a(in_a), .in_b(in_b),
    .out_valid(out_valid), .out_ready(out_ready), .out_result(out_result),
    .out_taken(out_taken), .busy(busy)
  );

  int_exec_unit #(.XLEN(32), .SHIFT_STEP(4)) dut4 (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid_4), .in_ready(in_ready_4),
    .in_funct3(in_funct3), .in_alt(in_alt), .in_br(in_br), .in_a(in_a), .in_b(in_b),
    .out_valid(out_valid_4), .out_ready(out_ready), .out_result(out_result_4),
    .out_taken(out_taken_4), .busy(busy_4)
  );

  // Reference: whole-operation arithmetic, {taken, result}
  function automatic logic [32:0] ref_op(input logic [2:0] f, input logic alt, input logic br,
                                         input logic [31:0] a, input logic [31:0] b);
    logic [31:0] r;
    logic        t;
    int          s;
    s = int'(b[4:0]);
    r = 32'h0;
    t = 1'b0;
`ifdef INT_EXEC_BRANCH_EN
    if (br) begin
      case (f)
        3'b000: t = (a == b);
        3'b001: t = (a != b);
        3'b100: t = ($signed(a) <  $signed(b));
        3'b101: t = ($signed(a) >= $signed(b));
        3'b110: t = (a <  b);
        3'b111: t = (a >= b);
        default: t = 1'b0;
      endcase
      return {t, 32'h0};
    end
`endif
    case (f)
      3'b000: r = alt ? a - b : a + b;
      3'b001: r = a << s;
      3'b010: r = ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
      3'b011: r = (a < b) ? 32'd1 : 32'd0;
      3'b100: r = a ^ b;
      3'b101: r = alt ? 32'($signed(a) >>> s) : a >> s;
      3'b110: r = a | b;
      default: r = a & b;
    endcase
    return {1'b0, r};
  endfunction

  function automatic int ref_lat(input logic [2:0] f, input logic br, input logic [31:0] b, input int step);
    bit brmode;
    int s;
    brmode = 1'b0;
`ifdef INT_EXEC_BRANCH_EN
    brmode = br;
`endif
    s = int'(b[4:0]);
    if (!brmode && (f == 3'b001 || f == 3'b101) && s > 0) return 1 + (s + step - 1) / step;
    return 1;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Drives one op into the selected instance and observes it through to its result (out_ready must be 1).
  task automatic issue(input bit sel4, input logic [2:0] f, input logic alt, input logic br,
                       input logic [31:0] a, input logic [31:0] b,
                       output logic [31:0] res, output logic tk, output int lat,
                       output int busy_cnt, output bit bad_shift, output bit tmo);
    int w;
    tmo = 1'b0; bad_shift = 1'b0; busy_cnt = 0; w = 0;
    in_funct3 = f; in_alt = alt; in_br = br; in_a = a; in_b = b;
    if (sel4) in_valid_4 = 1'b1; else in_valid = 1'b1;
    #1;
    while (!(sel4 ? in_ready_4 : in_ready) && w < 50) begin
      tick(); w++;
    end
    if (w >= 50) tmo = 1'b1;
    tick();
    in_valid = 1'b0; in_valid_4 = 1'b0;
    lat = 1;
    #1;
    while (!(sel4 ? out_valid_4 : out_valid) && lat < 200) begin
      if (sel4 ? busy_4 : busy) busy_cnt++;
      if (sel4 ? in_ready_4 : in_ready) bad_shift = 1'b1;
      tick();
      lat++;
    end
    if (lat >= 200) tmo = 1'b1;
    res = sel4 ? out_result_4 : out_result;
    tk  = sel4 ? out_taken_4 : out_taken;
    tick();
  endtask

  task automatic test_reset();
    rst_n = 1'b0; in_valid = 1'b0; in_valid_4 = 1'b0; out_ready = 1'b1;
    in_funct3 = 3'b000; in_alt = 1'b0; in_br = 1'b0; in_a = '0; in_b = '0;
    #12;
    n_checks++;
    if ({out_valid, out_taken, busy, in_ready} !== 4'b0000) begin
      n_fail++; $display("FAIL reset_ctrl: valid/taken/busy/ready=%b required 0000", {out_valid, out_taken, busy, in_ready});
    end
    n_checks++;
    if (out_result !== 32'h0) begin
      n_fail++; $display("FAIL reset_result: got %h required 00000000", out_result);
    end
    tick();
    rst_n = 1'b1;
    #1;
    n_checks++;
    if (in_ready !== 1'b1 || in_ready_4 !== 1'b1) begin
      n_fail++; $display("FAIL reset_release_ready: got %b/%b required 1/1", in_ready, in_ready_4);
    end
  endtask

  task automatic test_back_to_back();
    out_ready = 1'b1;
    tick();
    in_funct3 = 3'b000; in_alt = 1'b0; in_br = 1'b0; in_a = 32'h7FFFFFFF; in_b = 32'h1; in_valid = 1'b1;
    #1;
    n_checks++;
    if (in_ready !== 1'b1) begin n_fail++; $display("FAIL b2b_ready0: got %b required 1", in_ready); end
    tick();
    in_alt = 1'b1; in_a = 32'h0; in_b = 32'h1;
    #1;
    n_checks++;
    if (out_valid !== 1'b1 || out_result !== 32'h80000000) begin
      n_fail++; $display("FAIL b2b_add: valid=%b result=%h required 1 80000000", out_valid, out_result);
    end
    n_checks++;
    if (in_ready !== 1'b1) begin n_fail++; $display("FAIL b2b_ready1: got %b required 1", in_ready); end
    tick();
    in_valid = 1'b0;
    #1;
    n_checks++;
    if (out_valid !== 1'b1 || out_result !== 32'hFFFFFFFF) begin
      n_fail++; $display("FAIL b2b_sub: valid=%b result=%h required 1 ffffffff", out_valid, out_result);
    end
    tick();
    n_checks++;
    if (out_valid !== 1'b0) begin n_fail++; $display("FAIL b2b_drain: valid=%b required 0", out_valid); end
  endtask

  task automatic test_compare();
    logic [31:0] r; logic t; int lat, bc; bit bad, tmo;
    issue(1'b0, 3'b010, 1'b0, 1'b0, 32'hFFFFFFFF, 32'h1, r, t, lat, bc, bad, tmo);
    n_checks++;
    if (r !== 32'd1 || tmo) begin n_fail++; $display("FAIL slt: got %h required 00000001", r); end
    issue(1'b0, 3'b011, 1'b0, 1'b0, 32'hFFFFFFFF, 32'h1, r, t, lat, bc, bad, tmo);
    n_checks++;
    if (r !== 32'd0 || tmo) begin n_fail++; $display("FAIL sltu: got %h required 00000000", r); end
  endtask

  task automatic test_shift();
    logic [31:0] r; logic t; int lat, bc; bit bad, tmo;
    issue(1'b0, 3'b101, 1'b1, 1'b0, 32'h80000000, 32'h4, r, t, lat, bc, bad, tmo);
    n_checks++;
    if (r !== 32'hF8000000) begin n_fail++; $display("FAIL sra_result: got %h required f8000000", r); end
    n_checks++;
    if (lat !== 5 || bc !== 4) begin n_fail++; $display("FAIL sra_timing: latency=%0d busy=%0d required 5 4", lat, bc); end
    n_checks++;
    if (bad || tmo) begin n_fail++; $display("FAIL sra_ready_in_shift: bad=%b timeout=%b required 0 0", bad, tmo); end
    issue(1'b1, 3'b001, 1'b0, 1'b0, 32'h1, 32'd31, r, t, lat, bc, bad, tmo);
    n_checks++;
    if (r !== 32'h80000000 || lat !== 9) begin
      n_fail++; $display("FAIL sll_step4: result=%h latency=%0d required 80000000 9", r, lat);
    end
    issue(1'b1, 3'b001, 1'b0, 1'b0, 32'h1, 32'h20, r, t, lat, bc, bad, tmo);
    n_checks++;
    if (r !== 32'h1 || lat !== 1 || bc !== 0) begin
      n_fail++; $display("FAIL sll_shamt0: result=%h latency=%0d busy=%0d required 00000001 1 0", r, lat, bc);
    end
  endtask

  task automatic test_backpressure();
    tick();
    out_ready = 1'b0;
    in_funct3 = 3'b000; in_alt = 1'b0; in_br = 1'b0; in_a = 32'h1230; in_b = 32'h4; in_valid = 1'b1;
    tick();
    in_a = 32'd5; in_b = 32'd6;
    for (int i = 0; i < 3; i++) begin
      #1;
      n_checks++;
      if (out_valid !== 1'b1 || out_result !== 32'h1234 || in_ready !== 1'b0) begin
        n_fail++; $display("FAIL bp_hold%0d: valid=%b result=%h ready=%b required 1 00001234 0", i, out_valid, out_result, in_ready);
      end
      tick();
    end
    out_ready = 1'b1;
    #1;
    n_checks++;
    if (in_ready !== 1'b1) begin n_fail++; $display("FAIL bp_release_ready: got %b required 1", in_ready); end
    tick();
    in_valid = 1'b0;
    #1;
    n_checks++;
    if (out_valid !== 1'b1 || out_result !== 32'd11) begin
      n_fail++; $display("FAIL bp_new_result: valid=%b result=%h required 1 0000000b", out_valid, out_result);
    end
    tick();
    n_checks++;
    if (out_valid !== 1'b0) begin n_fail++; $display("FAIL bp_drain: valid=%b required 0", out_valid); end
  endtask

  task automatic test_reset_mid_shift();
    bit stale;
    out_ready = 1'b1;
    tick();
    in_funct3 = 3'b101; in_alt = 1'b1; in_br = 1'b0; in_a = 32'h80000000; in_b = 32'd20; in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    tick(); tick();
    rst_n = 1'b0;
    #1;
    n_checks++;
    if ({out_valid, busy, in_ready} !== 3'b000) begin
      n_fail++; $display("FAIL rst_mid_shift: valid/busy/ready=%b required 000", {out_valid, busy, in_ready});
    end
    tick();
    rst_n = 1'b1;
    #1;
    n_checks++;
    if (in_ready !== 1'b1) begin n_fail++; $display("FAIL rst_mid_release: ready=%b required 1", in_ready); end
    stale = 1'b0;
    for (int i = 0; i < 30; i++) begin
      if (out_valid || busy) stale = 1'b1;
      tick();
    end
    n_checks++;
    if (stale) begin n_fail++; $display("FAIL rst_mid_stale: stale=%b required 0", stale); end
  endtask

  task automatic test_branch();
    logic [31:0] r; logic t; int lat, bc; bit bad, tmo;
`ifdef INT_EXEC_BRANCH_EN
    issue(1'b0, 3'b110, 1'b0, 1'b1, 32'h1, 32'hFFFFFFFF, r, t, lat, bc, bad, tmo);
    n_checks++;
    if (t !== 1'b1 || r !== 32'h0) begin n_fail++; $display("FAIL bltu: taken=%b result=%h required 1 00000000", t, r); end
    issue(1'b0, 3'b100, 1'b0, 1'b1, 32'h1, 32'hFFFFFFFF, r, t, lat, bc, bad, tmo);
    n_checks++;
    if (t !== 1'b0 || r !== 32'h0) begin n_fail++; $display("FAIL blt: taken=%b result=%h required 0 00000000", t, r); end
`else
    issue(1'b0, 3'b000, 1'b0, 1'b1, 32'd3, 32'd4, r, t, lat, bc, bad, tmo);
    n_checks++;
    if (t !== 1'b0 || r !== 32'd7) begin n_fail++; $display("FAIL br_ignored: taken=%b result=%h required 0 00000007", t, r); end
`endif
  endtask

  task automatic test_random();
    logic [31:0] a, b, r; logic [2:0] f; logic alt, br, t; int lat, bc, step; bit bad, tmo, sel;
    logic [32:0] exp;
    out_ready = 1'b1;
    for (int i = 0; i < 60; i++) begin
      sel = (i >= 40);
      step = sel ? 4 : 1;
      f = 3'($urandom_range(0, 7));
      alt = 1'($urandom_range(0, 1));
      br = ($urandom_range(0, 3) == 0);
      a = $urandom();
      b = ($urandom_range(0, 1) == 0) ? 32'($urandom_range(0, 40)) : $urandom();
      exp = ref_op(f, alt, br, a, b);
      issue(sel, f, alt, br, a, b, r, t, lat, bc, bad, tmo);
      n_checks++;
      if (r !== exp[31:0] || t !== exp[32]) begin
        n_fail++; $display("FAIL rand%0d f=%0d alt=%b br=%b a=%h b=%h: got %b/%h required %b/%h",
                           i, f, alt, br, a, b, t, r, exp[32], exp[31:0]);
      end
      n_checks++;
      if (lat !== ref_lat(f, br, b, step) || bad || tmo) begin
        n_fail++; $display("FAIL rand%0d_lat: latency=%0d required %0d (bad=%b timeout=%b)", i, lat, ref_lat(f, br, b, step), bad, tmo);
      end
    end
  endtask

  initial begin
    test_reset();
    test_back_to_back();
    test_compare();
    test_shift();
    test_backpressure();
    test_reset_mid_shift();
    test_branch();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/int_exec_unit.md
Name: int_exec_unit

Overview:
- Parametrised integer execute unit for the RV integer datapath.
- Executes the eight OP/OP-IMM funct3 operations: ADD/SUB, AND, OR, XOR, SL, SR(L/A), SLT, SLTU.
- Shifts use an iterative shifter; all other operations complete in one cycle.
- Valid/ready handshake on input and output, with a single registered output slot.
- Sits between issue and writeback.

Parameters:
- XLEN, 32: operand/result width; 32 or 64.
- SHIFT_STEP, 1: bits shifted per cycle; power of two, 1..XLEN.

Ports:
- clk  in  1  clock.
- rst_n  in  1  reset, asynchronous, active-low.
- in_valid  in  1  operation offered.
- in_ready  out  1  unit accepts operation this cycle.
- in_funct3  in  3  funct3 encoding (ADD=000 SL=001 SLT=010 SLTU=011 XOR=100 SR=101 OR=110 AND=111).
- in_alt  in  1  funct7[5]: SUB when funct3=000, SRA when funct3=101; ignored otherwise.
- in_br  in  1  branch-compare mode (see Optional Feature).
- in_a  in  XLEN  operand A.
- in_b  in  XLEN  operand B / immediate; shamt = in_b[$clog2(XLEN)-1:0].
- out_valid  out  1  result held valid.
- out_ready  in  1  consumer takes result.
- out_result  out  XLEN  result.
- out_taken  out  1  branch outcome.
- busy  out  1  shift in progress.

Behaviour:
- Reset (async, rst_n low):
  - state=IDLE; out_valid=0, out_result=0, out_taken=0, busy=0.
  - in_ready forced 0 while rst_n low.
  - Reset mid-shift abandons the operation; no result is produced.
- States: IDLE, SHIFT.
- Handshake:
  - in_ready = rst_n && state==IDLE && (!out_valid || out_ready).
  - Accept on the edge where in_valid && in_ready.
  - Output transfer on the edge where out_valid && out_ready.
  - out_result and out_taken remain stable while out_valid && !out_ready.
  - out_valid drops after a transfer unless a new result is loaded on the same edge.
- Non-shift ops, and shifts with shamt=0:
  - Result loaded into the output register at the accept edge; out_valid=1 the next cycle (latency 1).
  - Throughput is 1/cycle when out_ready is held high.
- Shift ops with shamt s>0:
  - Accept edge loads the working register with in_a and remaining=s; state IDLE->SHIFT; busy=1.
  - Each SHIFT edge shifts by min(SHIFT_STEP, remaining) and decrements remaining.
  - The edge on which remaining<=SHIFT_STEP loads the output, sets out_valid=1, and returns to IDLE.
  - Latency = 1 + ceil(s/SHIFT_STEP) cycles.
  - in_ready=0 throughout SHIFT.
  - out_valid is always 0 during SHIFT, because the output slot was freed at accept.
- Arithmetic:
  - ADD/SUB wrap modulo 2^XLEN.
  - SLT is a signed compare and SLTU unsigned; result is zero-extended 0/1.
  - SRL fills with zeros; SRA fills with a[XLEN-1], replicated on every step.
  - Only the low $clog2(XLEN) bits of in_b are used as shamt.
- out_taken=0 for all non-branch operations.

Optional Feature:
- Macro: INT_EXEC_BRANCH_EN.
- Defined:
  - in_br=1 selects branch compare using the branch funct3 encoding: EQ=000 NE=001 LT=100 GE=101 LTU=110 GEU=111.
  - Single-cycle, same handshake as non-shift ops.
  - out_taken = compare result; out_result = 0.
  - funct3 010 or 011 with in_br=1 gives out_taken=0, out_result=0.
- Undefined:
  - in_br is ignored; the operation executes as an ALU op.
  - out_taken is tied 0.

Test Plan:
- XLEN=32, STEP=1; ADD a=0x7FFFFFFF b=1, then SUB (alt=1) a=0 b=1, back-to-back with out_ready=1 -> results 0x80000000 then 0xFFFFFFFF on consecutive cycles; in_ready stays 1.
- SLT a=0xFFFFFFFF b=1 -> 1; SLTU with the same operands -> 0.
- STEP=1; SRA (funct3=101, alt=1) a=0x80000000 b=4 -> 0xF8000000, out_valid 5 cycles after accept; busy=1 for 4 cycles; in_ready=0 during SHIFT.
- STEP=4; SLL a=1 b=31 -> 0x80000000 after 9 cycles. Also SLL with b=0x20 (shamt=0) -> result 1, latency 1.
- Backpressure: out_ready=0 with result 0x1234 held -> in_ready=0 and output stable for 3 cycles. Raise out_ready with a new ADD offered -> old result transfers and new op is accepted on the same edge.
- rst_n pulsed low mid-SRA -> out_valid=0, busy=0, in_ready=0 during reset, in_ready=1 after release, no stale result emitted. With INT_EXEC_BRANCH_EN defined: BLTU a=1 b=0xFFFFFFFF -> out_taken=1; BLT with the same operands -> out_taken=0.
